// File: rtl/ofdm_cp_inserter.sv
// OFDM cyclic-prefix inserter: ping-pong capture of N samples,
// replayed as the last CP samples followed by the full symbol.
module ofdm_cp_inserter #(
  parameter int N  = 32,
  parameter int CP = 16,
  parameter int W  = 16
) (
  input  logic         aclk,
  input  logic         areset,
  input  logic [W-1:0] s_tdata,
  input  logic         s_tvalid,
  input  logic         s_tlast,
  output logic         s_tready,
  output logic [W-1:0] m_tdata,
  output logic         m_tvalid,
  input  logic         m_tready,
  output logic         m_tuser,
  output logic         m_tlast,
  output logic         frame_err
);

  localparam int AW = $clog2(N);
  localparam int OW = $clog2(N + CP);

  localparam logic [AW-1:0] LP_LAST_IDX = AW'(N - 1);
  localparam logic [OW-1:0] LP_CP       = OW'(CP);
  localparam logic [OW-1:0] LP_PRE_BASE = OW'(N - CP);
  localparam logic [OW-1:0] LP_LAST_OC  = OW'(N + CP - 1);

  logic [W-1:0]  r_mem [2][N];
  logic [1:0]    r_full;
  logic          r_wr_bank;
  logic          r_rd_bank;
  logic [AW-1:0] r_wr_idx;
  logic [OW-1:0] r_oc;
  logic          r_frame_err;

  logic [1:0]    w_full_nxt;
  logic          w_wr_acc;
  logic          w_wr_last;
  logic          w_rd_hs;
  logic          w_rd_last;
  logic          w_in_cp;
  logic [OW-1:0] w_addr_ext;
  logic [AW-1:0] w_addr;

  assign s_tready  = ~r_full[r_wr_bank];
  assign m_tvalid  = r_full[r_rd_bank];
  assign frame_err = r_frame_err;

  assign w_wr_acc  = s_tvalid & s_tready;
  assign w_wr_last = (r_wr_idx == LP_LAST_IDX);
  assign w_rd_hs   = m_tvalid & m_tready;
  assign w_rd_last = (r_oc == LP_LAST_OC);
  assign w_in_cp   = (r_oc < LP_CP);

  // Prefix beats replay the tail of the block, then the whole block follows
  assign w_addr_ext = w_in_cp ? (r_oc + LP_PRE_BASE)
                              : (r_oc - LP_CP);
  assign w_addr     = w_addr_ext[AW-1:0];

  assign m_tdata = r_mem[r_rd_bank][w_addr];
  assign m_tuser = m_tvalid & w_in_cp;
  assign m_tlast = m_tvalid & w_rd_last;

  always_comb begin
    w_full_nxt = r_full;
    if (w_wr_acc && w_wr_last)
      w_full_nxt[r_wr_bank] = 1'b1;
    if (w_rd_hs && w_rd_last)
      w_full_nxt[r_rd_bank] = 1'b0;
  end

  always_ff @(posedge aclk) begin
    if (w_wr_acc)
      r_mem[r_wr_bank][r_wr_idx] <= s_tdata;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_full      <= '0;
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_wr_idx    <= '0;
      r_oc        <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_full <= w_full_nxt;
      if (w_wr_acc) begin
        if (w_wr_last) begin
          r_wr_idx  <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_wr_idx  <= r_wr_idx + AW'(1);
        end
        // Framing stays count-based; tlast only flags a mismatch
        if (s_tlast != w_wr_last)
          r_frame_err <= 1'b1;
      end
      if (w_rd_hs) begin
        if (w_rd_last) begin
          r_oc      <= '0;
          r_rd_bank <= ~r_rd_bank;
        end else begin
          r_oc      <= r_oc + OW'(1);
        end
      end
    end
  end

endmodule
